inst_fetch: RTL
===============

# inst_fetch

Instruction fetch stage driving the instruction ROM interface. It owns the program counter and the ROM chip-enable, and registers each returned instruction with its PC into the IF/ID pipeline register for the decode stage. It is the initiator side of the fetch protocol. The ROM responds combinationally from `ce` and `addr` within the same cycle. The stage also accepts pipeline stall, branch redirect and exception flush from control and decode.

## Interface
- `RESET_PC`, default 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- `clk`  input  1  single clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `stall`  input  1  hold PC and IF/ID register this cycle.
- `flush`  input  1  discard the fetched instruction and redirect to `flush_pc`.
- `flush_pc`  input  32  exception/return target.
- `branch_en`  input  1  taken-branch redirect from decode.
- `branch_target`  input  32  branch destination.
- `ce`  output  1  ROM chip enable; 1 means fetching.
- `addr`  output  32  ROM byte address; always equals `pc`.
- `inst`  input  32  ROM read data, valid combinationally in the same cycle as `ce`/`addr`.
- `pc`  output  32  current fetch PC.
- `id_pc`  output  32  IF/ID registered PC.
- `id_inst`  output  32  IF/ID registered instruction.
- `id_valid`  output  1  IF/ID holds a real instruction.

## Operation
- Reset (`rst_n`=0, asynchronous, takes effect immediately, including mid-operation):
  - `ce`=0, `pc`=`RESET_PC`.
  - `id_pc`=0, `id_inst`=0, `id_valid`=0.
- Start-up:
  - First rising edge with `rst_n`=1 sets `ce`=1.
  - `pc` stays `RESET_PC` on that edge.
  - `ce` then remains 1 until the next reset.
- PC update, on each edge with `ce`=1, in priority order:
  1. `flush`: `pc` <= `flush_pc`.
  2. `stall`: `pc` holds.
  3. `branch_en`: `pc` <= `branch_target`.
  4. Otherwise: `pc` <= `pc`+4.
- Address alignment and wrap:
  - `pc`[1:0] is forced to 00 on every load; target low bits are ignored.
  - Increment is modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- IF/ID update, on each edge:
  - `ce`=0: hold the reset values; `id_valid`=0.
  - `flush`: `id_inst` <= 0, `id_valid` <= 0; `id_pc` <= 0.
  - `stall` (no flush): all IF/ID fields hold.
  - Otherwise: `id_pc` <= `pc`, `id_inst` <= `inst`, `id_valid` <= 1.
  - This includes the cycle where `branch_en`=1. The instruction fetched in that cycle is the branch delay slot and is kept.
- Simultaneous events:
  - `flush` overrides `stall` and `branch_en`.
  - `stall` overrides `branch_en`. Decode holds `branch_en`/`branch_target` stable until the stall releases; this block does not latch them.
- `addr` = `pc` at all times. When `ce`=0 the ROM returns zero, and that value is never captured as valid.

## Timing
- Fetch latency: one cycle from PC to IF/ID. The instruction at PC=P appears on `id_inst` the edge after `pc`=P (no stall).
- Redirect latency:
  - `branch_en` or `flush` sampled at edge N gives `pc` = target after edge N.
  - The target instruction is in IF/ID after edge N+1.
- Reset to first valid instruction:
  - Edge 1 after release: `ce`=1.
  - Edge 2: `id_inst` = ROM[`RESET_PC`], `id_valid`=1, `pc`=`RESET_PC`+4.
- Throughput: one instruction per cycle while `stall`=0.

## Test plan
- **Reset/start-up:** release `rst_n`, ROM word0=32'h3401_1100 → edge 1 `ce`=1, `pc`=0; edge 2 `id_inst`=32'h3401_1100, `id_valid`=1, `pc`=4.
- **Sequential fetch:** run 4 cycles → `pc` goes 0,4,8,12,16; `id_pc` lags `pc` by one cycle; `id_inst` matches ROM words 0..3.
- **Stall:** `stall`=1 for 3 cycles at `pc`=8 → `pc`, `id_pc`, `id_inst` are frozen; after release `pc`=12 on the next edge.
- **Branch with delay slot:** `branch_en`=1, `branch_target`=32'h40 while `pc`=12 → next `pc`=32'h40 and `id_pc`=12 (delay slot kept); one edge later `id_pc`=32'h40. With `branch_target`=32'h43 → `pc`=32'h40.
- **Flush priority and wrap:**
  - `flush`=1, `stall`=1, `branch_en`=1, `flush_pc`=32'h180 → `pc`=32'h180, `id_valid`=0.
  - Separately, `pc`=32'hFFFF_FFFC with no stall → next `pc`=0.
- **Reset mid-run:** drop `rst_n` between edges at `pc`=32'h20 → `ce`, `pc`, `id_*` clear immediately without a clock edge; start-up then repeats exactly as in the first scenario.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC and ROM chip-enable, and captures each
// fetched word with its PC into the IF/ID register for decode.
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        branch_en,
   input  logic [31:0] branch_target,
   output logic        ce,
   output logic [31:0] addr,
   input  logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_valid
);

   typedef enum logic {S_IDLE, S_RUN} state_t;
   state_t state;

   assign addr = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         ce       <= 1'b0;
         pc       <= RESET_PC;
         id_pc    <= 32'h0;
         id_inst  <= 32'h0;
         id_valid <= 1'b0;
      end else begin
         case (state)
            // One idle edge after reset release: enable the ROM, keep PC at RESET_PC.
            S_IDLE: begin
               state <= S_RUN;
               ce    <= 1'b1;
            end
            S_RUN: begin
               if (flush) begin
                  pc       <= {flush_pc[31:2], 2'b00};
                  id_pc    <= 32'h0;
                  id_inst  <= 32'h0;
                  id_valid <= 1'b0;
               end else if (!stall) begin
                  // Word fetched alongside a taken branch is the delay slot and is kept.
                  pc       <= branch_en ? {branch_target[31:2], 2'b00} : pc + 32'd4;
                  id_pc    <= pc;
                  id_inst  <= inst;
                  id_valid <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
